inst_queue_param: RTL and testbench

//   Parametrised FIFO that buffers fetched instructions (inst + pc) between

---
 rtl/inst_queue_param.sv | 100 ++++++++++
 tb/tb_inst_queue_param.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue_param.sv
// Instruction queue between fetcher and decoder.
// First-word-fall-through FIFO carrying (inst, pc) pairs, with an occupancy
// count, an early-stall almost-full flag, a global freeze (rdy) and a
// mispredict flush (clr). All status flags are decoded from the count
// register, so no output depends combinationally on a same-cycle input.
module inst_queue_param #(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rdy,
  input  logic                       clr,
  input  logic                       IF_inst_valid,
  input  logic [DATA_W-1:0]          IF_inst,
  input  logic [PC_W-1:0]            IF_pc,
  output logic                       IF_queue_full,
  output logic                       IF_almost_full,
  input  logic                       ID_valid,
  output logic                       ID_inst_valid,
  output logic [DATA_W-1:0]          ID_inst,
  output logic [PC_W-1:0]            ID_pc,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  // Storage arrays; contents survive reset and flush, validity lives in count.
  logic [DATA_W-1:0] r_mem_inst [DEPTH];
  logic [PC_W-1:0]   r_mem_pc   [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;

  logic [PTR_W-1:0]  w_head_nxt;
  logic [PTR_W-1:0]  w_tail_nxt;
  logic [CNT_W-1:0]  w_count_nxt;
  logic              w_enq;
  logic              w_deq;
  logic              w_full;
  logic              w_empty;

  // Status decode from the count register only.
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);

  // Accepted transfers; offers while full and pops while empty are ignored.
  assign w_enq = IF_inst_valid & ~w_full;
  assign w_deq = ID_valid & ~w_empty;

  // Next-state for pointers and occupancy; rdy=0 holds everything.
  always_comb begin
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    w_count_nxt = r_count;
    if (rdy) begin
      if (w_enq) w_tail_nxt = r_tail + PTR_W'(1);
      if (w_deq) w_head_nxt = r_head + PTR_W'(1);
      case ({w_enq, w_deq})
        2'b10:   w_count_nxt = r_count + CNT_W'(1);
        2'b01:   w_count_nxt = r_count - CNT_W'(1);
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Pointer/count registers; reset and flush share the same empty state.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Array write at the tail; a flush or reset discards the same-cycle offer.
  always_ff @(posedge clk) begin
    if (!rst && !clr && rdy && w_enq) begin
      r_mem_inst[r_tail] <= IF_inst;
      r_mem_pc[r_tail]   <= IF_pc;
    end
  end

  // Outputs: flags from count, head entry forced to zero while empty.
  assign IF_queue_full  = w_full;
  assign IF_almost_full = ((CNT_W'(DEPTH) - r_count) <= CNT_W'(AF_MARGIN));
  assign ID_inst_valid  = ~w_empty;
  assign ID_inst        = w_empty ? '0 : r_mem_inst[r_head];
  assign ID_pc          = w_empty ? '0 : r_mem_pc[r_head];
  assign count          = r_count;

endmodule

// File: tb/tb_inst_queue_param.sv
// Directed bench for inst_queue_param: a 16-deep instance and a 4-deep one.
module tb_inst_queue_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // 16-deep, 32-bit instance
  logic        a_rst = 1'b1, a_rdy = 1'b1, a_clr = 1'b0;
  logic        a_v = 1'b0, a_idv = 1'b0;
  logic [31:0] a_inst = '0, a_pc = '0;
  logic        a_full, a_af, a_ival;
  logic [31:0] a_oinst, a_opc;
  logic [4:0]  a_count;

  // 4-deep, 16-bit instance
  logic        b_rst = 1'b1, b_v = 1'b0, b_idv = 1'b0;
  logic [15:0] b_inst = '0;
  logic [31:0] b_pc = '0;
  logic        b_full, b_af, b_ival;
  logic [15:0] b_oinst;
  logic [31:0] b_opc;
  logic [2:0]  b_count;

  inst_queue_param #(.DEPTH(16), .DATA_W(32), .PC_W(32), .AF_MARGIN(2)) u_a (
    .clk(clk), .rst(a_rst), .rdy(a_rdy), .clr(a_clr),
    .IF_inst_valid(a_v), .IF_inst(a_inst), .IF_pc(a_pc),
    .IF_queue_full(a_full), .IF_almost_full(a_af),
    .ID_valid(a_idv), .ID_inst_valid(a_ival), .ID_inst(a_oinst), .ID_pc(a_opc),
    .count(a_count)
  );

  inst_queue_param #(.DEPTH(4), .DATA_W(16), .PC_W(32), .AF_MARGIN(2)) u_b (
    .clk(clk), .rst(b_rst), .rdy(1'b1), .clr(1'b0),
    .IF_inst_valid(b_v), .IF_inst(b_inst), .IF_pc(b_pc),
    .IF_queue_full(b_full), .IF_almost_full(b_af),
    .ID_valid(b_idv), .ID_inst_valid(b_ival), .ID_inst(b_oinst), .ID_pc(b_opc),
    .count(b_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Occupancy must stay within DEPTH on both instances.
  always @(negedge clk) begin
    assert (a_count <= 5'd16 && b_count <= 3'd4) else begin
      n_fail++;
      $error("FAIL count_bound observed=%0d/%0d expected<=16/4", a_count, b_count);
    end
  end

  initial begin
    // ---- reset state
    step(); step();
    a_rst = 1'b0; b_rst = 1'b0;
    chk("rst_count", 64'(a_count), 64'd0);
    chk("rst_valid", 64'(a_ival), 64'd0);
    chk("rst_pc",    64'(a_opc),  64'd0);
    chk("rst_inst",  64'(a_oinst), 64'd0);
    chk("rst_full",  64'(a_full), 64'd0);
    chk("rst_af",    64'(a_af),   64'd0);

    // ---- 1: three entries in, out in order
    for (int i = 0; i < 3; i++) begin
      a_v = 1'b1; a_pc = 32'(i * 4); a_inst = 32'(32'hA0 + i);
      step();
      chk("t1_valid_after_enq", 64'(a_ival), 64'd1);
      chk("t1_head_pc", 64'(a_opc), 64'h0);
    end
    a_v = 1'b0;
    chk("t1_count3", 64'(a_count), 64'd3);
    a_idv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("t1_deq_pc",   64'(a_opc),   64'(i * 4));
      chk("t1_deq_inst", 64'(a_oinst), 64'(32'hA0 + i));
      step();
    end
    a_idv = 1'b0;
    chk("t1_empty_valid", 64'(a_ival), 64'd0);
    chk("t1_empty_pc",    64'(a_opc),  64'd0);

    // ---- 2: fill to full, almost-full threshold, dropped offers
    for (int i = 0; i < 16; i++) begin
      a_v = 1'b1; a_pc = 32'(i * 4); a_inst = 32'(32'hB0 + i);
      step();
      chk("t2_count", 64'(a_count), 64'(i + 1));
      chk("t2_af",    64'(a_af),    64'((i + 1) >= 14));
      chk("t2_full",  64'(a_full),  64'((i + 1) == 16));
    end
    a_pc = 32'h40; a_inst = 32'hEE;
    step();
    chk("t2_drop_count", 64'(a_count), 64'd16);
    chk("t2_drop_head",  64'(a_opc),   64'h0);
    a_pc = 32'h44; a_idv = 1'b1;
    step();
    chk("t2_full_deq_enq_count", 64'(a_count), 64'd15);
    chk("t2_full_deq_enq_head",  64'(a_opc),   64'h4);
    chk("t2_full_clear",         64'(a_full),  64'd0);
    a_v = 1'b0;
    for (int i = 1; i < 16; i++) begin
      chk("t2_drain_pc", 64'(a_opc), 64'(i * 4));
      step();
    end
    a_idv = 1'b0;
    chk("t2_drained", 64'(a_ival), 64'd0);

    // ---- 3: continuous streaming with pointer wrap
    a_v = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_pc = 32'(32'h2000 + i * 4);
      step();
    end
    a_idv = 1'b1;
    for (int i = 3; i < 43; i++) begin
      a_pc = 32'(32'h2000 + i * 4);
      chk("t3_stream_head", 64'(a_opc), 64'(32'h2000 + (i - 3) * 4));
      step();
      chk("t3_stream_count", 64'(a_count), 64'd3);
    end
    a_v = 1'b0;
    for (int i = 40; i < 43; i++) begin
      chk("t3_tail_pc", 64'(a_opc), 64'(32'h2000 + i * 4));
      step();
    end
    a_idv = 1'b0;
    chk("t3_empty", 64'(a_count), 64'd0);

    // ---- 4: flush discards queued and same-cycle traffic
    a_v = 1'b1;
    for (int i = 0; i < 5; i++) begin
      a_pc = 32'(32'h300 + i * 4);
      step();
    end
    chk("t4_count5", 64'(a_count), 64'd5);
    a_clr = 1'b1; a_pc = 32'h999; a_idv = 1'b1;
    step();
    a_clr = 1'b0; a_idv = 1'b0;
    chk("t4_clr_count", 64'(a_count), 64'd0);
    chk("t4_clr_valid", 64'(a_ival),  64'd0);
    chk("t4_clr_pc",    64'(a_opc),   64'd0);
    a_pc = 32'h100;
    step();
    a_v = 1'b0;
    chk("t4_first_after_clr", 64'(a_opc),   64'h100);
    chk("t4_count1",          64'(a_count), 64'd1);
    a_idv = 1'b1;
    step();
    a_idv = 1'b0;

    // ---- 5: rdy=0 freezes, resume, reset while frozen
    a_v = 1'b1;
    a_pc = 32'h500; step();
    a_pc = 32'h504; step();
    a_rdy = 1'b0; a_pc = 32'h508; a_idv = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_hold_count", 64'(a_count), 64'd2);
      chk("t5_hold_pc",    64'(a_opc),   64'h500);
    end
    a_rdy = 1'b1;
    step();
    a_v = 1'b0; a_idv = 1'b0;
    chk("t5_resume_count", 64'(a_count), 64'd2);
    chk("t5_resume_pc",    64'(a_opc),   64'h504);
    a_rdy = 1'b0; a_rst = 1'b1;
    step();
    a_rst = 1'b0; a_rdy = 1'b1;
    chk("t5_rst_frozen_count", 64'(a_count), 64'd0);
    chk("t5_rst_frozen_valid", 64'(a_ival),  64'd0);

    // ---- 6: 4-deep instance
    b_v = 1'b1; b_pc = 32'h10; b_inst = 16'h1111;
    step();
    chk("t6_count1", 64'(b_count), 64'd1);
    b_pc = 32'h14; b_inst = 16'h2222; b_idv = 1'b1;
    step();
    b_idv = 1'b0;
    chk("t6_swap_count", 64'(b_count), 64'd1);
    chk("t6_swap_pc",    64'(b_opc),   64'h14);
    chk("t6_swap_inst",  64'(b_oinst), 64'h2222);
    chk("t6_af_at1",     64'(b_af),    64'd0);
    for (int i = 2; i <= 4; i++) begin
      b_pc = 32'(32'h14 + (i - 1) * 4); b_inst = 16'(16'h2222 + i);
      step();
      chk("t6_count", 64'(b_count), 64'(i));
      chk("t6_af",    64'(b_af),    64'd1);
      chk("t6_full",  64'(b_full),  64'(i == 4));
    end
    b_pc = 32'h99;
    step();
    b_v = 1'b0;
    chk("t6_drop_count", 64'(b_count), 64'd4);
    chk("t6_head_kept",  64'(b_opc),   64'h14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
